crypto_regfile: RTL and testbench

Parametrised register file for the mini crypto processor datapath: two combinational read ports, one synchronous write port, and a per-entry reset image. Adds an optional write-through bypass, an optional hard-wired zero register, and a sequential zeroize engine that wipes every entry on command to clear key material. It replaces the fixed 16x8 register file between decode and the ALU.

---
 rtl/crypto_pkg.sv | 22 ++
 rtl/crypto_regfile_if.sv | 39 +++
 rtl/regfile_wipe_ctrl.sv | 79 +++++++
 rtl/crypto_regfile.sv | 97 +++++++++
 tb/tb_crypto_regfile.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// ----------------------------------------------------------------------------
// crypto_pkg
// Shared definitions for the crypto processor register file.
//   wipe_state_t  : zeroize engine states (IDLE, WIPE)
//   DEF_DATA_W    : default register width
//   DEF_ADDR_W    : default register index width
//   DEF_INIT_VEC  : default reset image (r2 = 0x41, r3 = 0x20, all others 0)
// ----------------------------------------------------------------------------
package crypto_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WIPE = 1'b1
    } wipe_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [(2**DEF_ADDR_W)*DEF_DATA_W-1:0] DEF_INIT_VEC =
        128'h0000_0000_0000_0000_0000_0000_2041_0000;

endpackage

// File: rtl/crypto_regfile_if.sv
// ----------------------------------------------------------------------------
// crypto_regfile_if
// Decode/ALU-side bus of the register file.
//   reg_write, rd, write_data : write port
//   rs1, rs2                  : read indices
//   out_rs1, out_rs2          : read data
//   zeroize_req               : wipe request
//   busy, zeroize_done        : wipe status
//   wr_drop                   : write discarded because a wipe is running
// The master modport drives requests; the slave modport is the register file.
// ----------------------------------------------------------------------------
interface crypto_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);

    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] out_rs1;
    logic [DATA_W-1:0] out_rs2;
    logic              zeroize_req;
    logic              busy;
    logic              zeroize_done;
    logic              wr_drop;

    modport master (
        output reg_write, rd, write_data, rs1, rs2, zeroize_req,
        input  out_rs1, out_rs2, busy, zeroize_done, wr_drop
    );

    modport slave (
        input  reg_write, rd, write_data, rs1, rs2, zeroize_req,
        output out_rs1, out_rs2, busy, zeroize_done, wr_drop
    );

endinterface

// File: rtl/regfile_wipe_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_wipe_ctrl
// Zeroize engine: walks a pointer over every register entry, one per cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   zeroize_req   : start a wipe (only honoured while idle)
//   busy          : registered, high for exactly 2**ADDR_W cycles per wipe
//   zeroize_done  : registered, one-cycle pulse after the last entry clears
//   wipe_ptr      : entry being cleared this cycle (valid while busy)
// ----------------------------------------------------------------------------
module regfile_wipe_ctrl
    import crypto_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              zeroize_req,
    output logic              busy,
    output logic              zeroize_done,
    output logic [ADDR_W-1:0] wipe_ptr
);

    wipe_state_t       state_q;
    wipe_state_t       state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              busy_d;
    logic              done_d;

    // State, pointer and status flags; reset drops any wipe in flight
    // without raising zeroize_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            busy         <= 1'b0;
            zeroize_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy         <= busy_d;
            zeroize_done <= done_d;
        end
    end

    // Next-state logic. busy is registered from the next state so it is
    // high exactly while state_q is WIPE. The pointer wraps back to 0 on
    // the final increment, leaving it ready for the next wipe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (zeroize_req) begin
                    state_d = WIPE;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            WIPE: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wipe_ptr = ptr_q;

endmodule

// File: rtl/crypto_regfile.sv
// ----------------------------------------------------------------------------
// crypto_regfile
// Parametrised register file: two combinational read ports, one synchronous
// write port, per-entry reset image, optional write-through bypass, optional
// hard-wired zero r0, and a sequential zeroize engine for key material.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : crypto_regfile_if slave (write port, read ports, wipe
//                request and status, wr_drop)
// ----------------------------------------------------------------------------
module crypto_regfile
    import crypto_pkg::*;
#(
    parameter int                                DATA_W   = DEF_DATA_W,
    parameter int                                ADDR_W   = DEF_ADDR_W,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]     INIT_VEC = DEF_INIT_VEC,
    parameter bit                                BYPASS   = 1'b1,
    parameter bit                                ZERO_R0  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    crypto_regfile_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              busy;
    logic              zeroize_done;
    logic [ADDR_W-1:0] wipe_ptr;
    logic              write_ok;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;

    regfile_wipe_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_wipe_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .zeroize_req  (bus.zeroize_req),
        .busy         (busy),
        .zeroize_done (zeroize_done),
        .wipe_ptr     (wipe_ptr)
    );

    assign write_ok = bus.reg_write && !busy && !(ZERO_R0 && (bus.rd == '0));

    // Storage. The wipe owns the array while busy, so a write and a request
    // in the same idle cycle commit the write first and the wipe erases it
    // later. Zeroize clears to 0 rather than restoring the reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= INIT_VEC[i*DATA_W +: DATA_W];
            end
        end else if (busy) begin
            regs[wipe_ptr] <= '0;
        end else if (write_ok) begin
            regs[bus.rd] <= bus.write_data;
        end
    end

    // Read port 1: array, then bypass, then r0 clamp, then the wipe mask,
    // which hides entries not yet cleared as well.
    always_comb begin
        read1 = regs[bus.rs1];
        if (BYPASS && bus.reg_write && (bus.rd == bus.rs1)) begin
            read1 = bus.write_data;
        end
        if (ZERO_R0 && (bus.rs1 == '0)) begin
            read1 = '0;
        end
        if (busy) begin
            read1 = '0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        read2 = regs[bus.rs2];
        if (BYPASS && bus.reg_write && (bus.rd == bus.rs2)) begin
            read2 = bus.write_data;
        end
        if (ZERO_R0 && (bus.rs2 == '0)) begin
            read2 = '0;
        end
        if (busy) begin
            read2 = '0;
        end
    end

    assign bus.out_rs1      = read1;
    assign bus.out_rs2      = read2;
    assign bus.busy         = busy;
    assign bus.zeroize_done = zeroize_done;
    assign bus.wr_drop      = bus.reg_write & busy;

endmodule

// File: tb/tb_crypto_regfile.sv
// ----------------------------------------------------------------------------
// tb_crypto_regfile
// Three register files share one stimulus stream:
//   a : defaults (8x16, BYPASS=1, ZERO_R0=0)
//   b : 8x16, BYPASS=0, ZERO_R0=1
//   c : 32x8, BYPASS=1, ZERO_R0=0, custom reset image
// A behavioural model (arrays plus a remaining-wipe-cycles counter per
// build) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_crypto_regfile;

    localparam logic [255:0] INIT_C =
        256'h0000_0000_1234_5678_0000_0000_0000_0000_0000_0000_0000_0000_DEAD_BEEF_0000_0000;

    logic clk;
    logic rst_n;

    crypto_regfile_if #(.DATA_W(8),  .ADDR_W(4)) bus_a ();
    crypto_regfile_if #(.DATA_W(8),  .ADDR_W(4)) bus_b ();
    crypto_regfile_if #(.DATA_W(32), .ADDR_W(3)) bus_c ();

    crypto_regfile #(.BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    crypto_regfile #(.BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    crypto_regfile #(.DATA_W(32), .ADDR_W(3), .INIT_VEC(INIT_C),
                     .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Current stimulus, shared by all three builds.
    logic        cur_we;
    logic [3:0]  cur_rd;
    logic [31:0] cur_wd;
    logic [3:0]  cur_rs1;
    logic [3:0]  cur_rs2;
    logic        cur_zq;

    // Reference model state per build.
    logic [31:0] mem [3][16];
    int          wipe_left [3];
    logic        done_exp [3];
    int          depth_of [3] = '{16, 16, 8};
    logic [31:0] mask_of [3]  = '{32'hFF, 32'hFF, 32'hFFFF_FFFF};
    bit          bypass_of [3] = '{1'b1, 1'b0, 1'b1};
    bit          zr0_of [3]    = '{1'b0, 1'b1, 1'b0};

    int n_compared;
    int n_mismatched;
    int busy_cnt_a;
    int busy_cnt_c;
    int done_cnt_a;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        logic [255:0] init_c_v;
        init_c_v = INIT_C;
        for (int c = 0; c < 3; c++) begin
            wipe_left[c] = 0;
            done_exp[c]  = 1'b0;
            for (int i = 0; i < 16; i++) mem[c][i] = 32'h0;
        end
        mem[0][2] = 32'h41; mem[0][3] = 32'h20;
        mem[1][2] = 32'h41; mem[1][3] = 32'h20;
        for (int i = 0; i < 8; i++) mem[2][i] = init_c_v[i*32 +: 32];
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge();
        int w;
        for (int c = 0; c < 3; c++) begin
            w = int'(cur_rd) & (depth_of[c] - 1);
            done_exp[c] = 1'b0;
            if (wipe_left[c] > 0) begin
                mem[c][depth_of[c] - wipe_left[c]] = 32'h0;
                wipe_left[c] = wipe_left[c] - 1;
                if (wipe_left[c] == 0) done_exp[c] = 1'b1;
            end else begin
                if (cur_we && !(zr0_of[c] && w == 0)) mem[c][w] = cur_wd & mask_of[c];
                if (cur_zq) wipe_left[c] = depth_of[c];
            end
        end
    endtask

    function automatic logic [31:0] exp_read(input int c, input logic [3:0] addr);
        int a;
        int w;
        a = int'(addr) & (depth_of[c] - 1);
        w = int'(cur_rd) & (depth_of[c] - 1);
        if (wipe_left[c] > 0) return 32'h0;
        if (zr0_of[c] && a == 0) return 32'h0;
        if (bypass_of[c] && cur_we && a == w) return cur_wd & mask_of[c];
        return mem[c][a];
    endfunction

    function automatic logic [31:0] exp_busy(input int c);
        return (wipe_left[c] > 0) ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] exp_drop(input int c);
        return (cur_we && wipe_left[c] > 0) ? 32'h1 : 32'h0;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".a.rs1"},  32'(bus_a.out_rs1),      exp_read(0, cur_rs1));
        checkOutput({tag, ".a.rs2"},  32'(bus_a.out_rs2),      exp_read(0, cur_rs2));
        checkOutput({tag, ".a.busy"}, 32'(bus_a.busy),         exp_busy(0));
        checkOutput({tag, ".a.done"}, 32'(bus_a.zeroize_done), 32'(done_exp[0]));
        checkOutput({tag, ".a.drop"}, 32'(bus_a.wr_drop),      exp_drop(0));
        checkOutput({tag, ".b.rs1"},  32'(bus_b.out_rs1),      exp_read(1, cur_rs1));
        checkOutput({tag, ".b.rs2"},  32'(bus_b.out_rs2),      exp_read(1, cur_rs2));
        checkOutput({tag, ".b.busy"}, 32'(bus_b.busy),         exp_busy(1));
        checkOutput({tag, ".b.done"}, 32'(bus_b.zeroize_done), 32'(done_exp[1]));
        checkOutput({tag, ".b.drop"}, 32'(bus_b.wr_drop),      exp_drop(1));
        checkOutput({tag, ".c.rs1"},  bus_c.out_rs1,           exp_read(2, cur_rs1));
        checkOutput({tag, ".c.rs2"},  bus_c.out_rs2,           exp_read(2, cur_rs2));
        checkOutput({tag, ".c.busy"}, 32'(bus_c.busy),         exp_busy(2));
        checkOutput({tag, ".c.done"}, 32'(bus_c.zeroize_done), 32'(done_exp[2]));
        checkOutput({tag, ".c.drop"}, 32'(bus_c.wr_drop),      exp_drop(2));
        if (bus_a.busy) busy_cnt_a++;
        if (bus_c.busy) busy_cnt_c++;
        if (bus_a.zeroize_done) done_cnt_a++;
    endtask

    task automatic drive_buses();
        bus_a.reg_write = cur_we; bus_a.rd = cur_rd; bus_a.write_data = cur_wd[7:0];
        bus_a.rs1 = cur_rs1; bus_a.rs2 = cur_rs2; bus_a.zeroize_req = cur_zq;
        bus_b.reg_write = cur_we; bus_b.rd = cur_rd; bus_b.write_data = cur_wd[7:0];
        bus_b.rs1 = cur_rs1; bus_b.rs2 = cur_rs2; bus_b.zeroize_req = cur_zq;
        bus_c.reg_write = cur_we; bus_c.rd = cur_rd[2:0]; bus_c.write_data = cur_wd;
        bus_c.rs1 = cur_rs1[2:0]; bus_c.rs2 = cur_rs2[2:0]; bus_c.zeroize_req = cur_zq;
    endtask

    // Drive one cycle's inputs at the falling edge and check all outputs.
    task automatic applyStimulus(input logic we, input logic [3:0] rd,
                                 input logic [31:0] wd, input logic [3:0] a1,
                                 input logic [3:0] a2, input logic zq,
                                 input string tag);
        @(negedge clk);
        cur_we = we; cur_rd = rd; cur_wd = wd;
        cur_rs1 = a1; cur_rs2 = a2; cur_zq = zq;
        drive_buses();
        #1;
        checkAll(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
    endtask

    task automatic step(input logic we, input logic [3:0] rd, input logic [31:0] wd,
                        input logic [3:0] a1, input logic [3:0] a2, input logic zq,
                        input string tag);
        applyStimulus(we, rd, wd, a1, a2, zq, tag);
        tick();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        busy_cnt_a   = 0;
        busy_cnt_c   = 0;
        done_cnt_a   = 0;
        cur_we = 1'b0; cur_rd = '0; cur_wd = '0;
        cur_rs1 = '0; cur_rs2 = '0; cur_zq = 1'b0;
        drive_buses();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();

        // Reset image.
        applyStimulus(1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b0, "rst");
        checkOutput("rst.r2", 32'(bus_a.out_rs1), 32'h41);
        checkOutput("rst.r3", 32'(bus_a.out_rs2), 32'h20);
        checkOutput("rst.busy", 32'(bus_a.busy), 32'h0);
        checkOutput("rst.c.r1", bus_c.out_rs2, 32'h0);
        applyStimulus(1'b0, 4'd0, 32'h0, 4'd5, 4'd1, 1'b0, "rst5");
        checkOutput("rst.r5", 32'(bus_a.out_rs1), 32'h0);
        checkOutput("rst.c.deadbeef", bus_c.out_rs2, 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b1;

        // Write and bypass.
        applyStimulus(1'b1, 4'd7, 32'hCAFE_F0A5, 4'd7, 4'd2, 1'b0, "byp");
        checkOutput("byp.a", 32'(bus_a.out_rs1), 32'hA5);
        checkOutput("nobyp.b", 32'(bus_b.out_rs1), 32'h0);
        checkOutput("byp.c", bus_c.out_rs1, 32'hCAFE_F0A5);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd3, 1'b0, "wrrd");
        checkOutput("wrrd.a", 32'(bus_a.out_rs1), 32'hA5);
        checkOutput("wrrd.b", 32'(bus_b.out_rs1), 32'hA5);
        tick();

        // Zero register.
        step(1'b1, 4'd0, 32'hFF, 4'd0, 4'd0, 1'b0, "r0wr");
        applyStimulus(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, "r0rd");
        checkOutput("r0.a", 32'(bus_a.out_rs1), 32'hFF);
        checkOutput("r0.b", 32'(bus_b.out_rs1), 32'h0);
        tick();

        // Fill every entry, then wipe with a dropped write mid-wipe.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), $urandom | 32'h1, 4'(i), 4'(15 - i), 1'b0, "fill");
        end
        busy_cnt_a = 0; busy_cnt_c = 0; done_cnt_a = 0;
        step(1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b1, "zreq");
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                applyStimulus(1'b1, 4'd4, 32'h77, 4'd4, 4'd9, 1'b0, "wipewr");
                checkOutput("wipe.drop", 32'(bus_a.wr_drop), 32'h1);
                checkOutput("wipe.masked", 32'(bus_a.out_rs2), 32'h0);
                tick();
            end else begin
                step(1'b0, 4'd0, 32'h0, 4'(k), 4'(15 - k), 1'b0, "wipe");
            end
        end
        checkOutput("wipe.busyLenA", 32'(busy_cnt_a), 32'd16);
        checkOutput("wipe.busyLenC", 32'(busy_cnt_c), 32'd8);
        checkOutput("wipe.donePulses", 32'(done_cnt_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'd0, 32'h0, 4'(i), 4'd4, 1'b0, "wiped");
            checkOutput("wiped.a", 32'(bus_a.out_rs1), 32'h0);
            tick();
        end
        checkOutput("wiped.r4", 32'(bus_a.out_rs2), 32'h0);

        // Reset in the middle of a wipe.
        step(1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b1, "mreq");
        for (int k = 0; k < 5; k++) step(1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b0, "mwipe");
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("midrst.r2", 32'(bus_a.out_rs1), 32'h41);
        checkOutput("midrst.busy", 32'(bus_a.busy), 32'h0);
        checkOutput("midrst.done", 32'(bus_a.zeroize_done), 32'h0);
        checkAll("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt_a = 0;
        for (int k = 0; k < 20; k++) step(1'b0, 4'd0, 32'h0, 4'd3, 4'd2, 1'b0, "postrst");
        checkOutput("midrst.noDone", 32'(done_cnt_a), 32'h0);

        // Request held high across the done edge.
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 4'd0, 32'h0, 4'($urandom), 4'($urandom), 1'b1, "hold");
        end
        for (int k = 0; k < 20; k++) step(1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 1'b0, "drain");

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                 4'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
